// File: rtl/mips_dbg_pkg.sv
// Shared types and sizing helpers for the MIPS debug observation serializer.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } dbg_state_e;

  function automatic int calc_beats(input int data_w, input int num_ch, input int out_w);
    return (num_ch * data_w) / out_w;
  endfunction

  function automatic int calc_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit lanes_divide(input int data_w, input int out_w);
    return (out_w > 0) && ((data_w % out_w) == 0);
  endfunction

endpackage

// File: rtl/mips_dbg_serializer.sv
// Snapshots NUM_CH words and streams them over OUT_W pins as framed beats.
// Optional DBG_PARITY_EN adds a registered even-parity pin (dout_par).
module mips_dbg_serializer
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_CH  = 2,
  parameter int OUT_W   = 4,
  parameter int GAP_CYC = 1,
  parameter int FCNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     cont_mode,
  input  logic                     trig,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [OUT_W-1:0]         dout,
  output logic                     dout_valid,
  output logic                     frame_sync,
  output logic                     busy,
  output logic [FCNT_W-1:0]        frame_cnt
`ifdef DBG_PARITY_EN
  ,
  output logic                     dout_par
`endif
);

  localparam int SNAP_W = NUM_CH * DATA_W;
  localparam int BEATS  = calc_beats(DATA_W, NUM_CH, OUT_W);
  localparam int BCNT_W = calc_cnt_w(BEATS);
  localparam int GAP_W  = calc_cnt_w((GAP_CYC > 0) ? GAP_CYC : 1);
  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BEATS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  if (!lanes_divide(DATA_W, OUT_W)) begin : g_chk_lanes
    $error("OUT_W must divide DATA_W");
  end

  dbg_state_e          state_q, state_d;
  logic [BCNT_W-1:0]   beat_q, beat_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic                pending_q, pending_d;
  logic [FCNT_W-1:0]   fcnt_q;
  logic [OUT_W-1:0]    dout_q, dout_d;
  logic                vld_q, sync_q, busy_q;
  logic                start, load, frame_done;

  always_comb begin
    start      = en & (cont_mode | trig | pending_q);
    state_d    = state_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    snap_d     = snap_q;
    load       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: load = start;
      SHIFT: begin
        if (beat_q == BEAT_LAST) begin
          frame_done = 1'b1;
          if (GAP_CYC > 0) begin
            state_d = GAP;
            gap_d   = '0;
          end else if (start) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          beat_d = beat_q + BCNT_W'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (start) load = 1'b1;
          else       state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = SHIFT;
      beat_d  = '0;
      snap_d  = ch_data;
    end
    // A trigger arriving mid-frame is remembered; any number collapse to one.
    pending_d = load ? 1'b0 : ((trig && state_q != IDLE) ? 1'b1 : pending_q);
    // Outputs are computed from next state so beat 0 lands on the start edge.
    dout_d = (state_d == SHIFT) ? snap_d[int'(beat_d)*OUT_W +: OUT_W] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      gap_q     <= '0;
      snap_q    <= '0;
      pending_q <= 1'b0;
      fcnt_q    <= '0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
      sync_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      snap_q    <= snap_d;
      pending_q <= pending_d;
      fcnt_q    <= fcnt_q + FCNT_W'(frame_done);
      dout_q    <= dout_d;
      vld_q     <= (state_d == SHIFT);
      sync_q    <= (state_d == SHIFT) && (beat_d == '0);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign frame_sync = sync_q;
  assign busy       = busy_q;
  assign frame_cnt  = fcnt_q;

`ifdef DBG_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= ^dout_d;
  end
  assign dout_par = par_q;
`endif

endmodule
